// File: rtl/pdm_tx.sv
// pdm_tx: FIFO-buffered signed PCM to single-bit PDM transmitter (2nd-order sigma-delta).
// Define PDM_TX_DITHER_EN to add LFSR dither into the second integrator.
module pdm_tx #(
  parameter int CLK_DIV    = 10,
  parameter int OSR        = 64,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pdmClk,
  output logic              pdmData,
  output logic              underrun
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int ACC_W = DATA_W + 4;
  localparam int SUM_W = ACC_W + 2;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;
  localparam logic signed [SUM_W-1:0] FB_POS  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] FB_NEG  = ~FB_POS;

  function automatic logic signed [SUM_W-1:0] sx_acc(input logic signed [ACC_W-1:0] v);
    return $signed({{(SUM_W-ACC_W){v[ACC_W-1]}}, v});
  endfunction

  function automatic logic signed [SUM_W-1:0] sx_dat(input logic signed [DATA_W-1:0] v);
    return $signed({{(SUM_W-DATA_W){v[DATA_W-1]}}, v});
  endfunction

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SUM_MAX)      return ACC_MAX;
    else if (v < SUM_MIN) return ACC_MIN;
    else                  return v[ACC_W-1:0];
  endfunction

  // Sample FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              full, empty, push, pop;

  // Divider, bit counter and modulator state
  logic [DIV_W-1:0]         div_cnt_reg, div_next;
  logic [BIT_W-1:0]         bit_cnt_reg;
  logic signed [DATA_W-1:0] x_reg, x_eff;
  logic signed [ACC_W-1:0]  acc1_reg, acc2_reg, acc1_next, acc2_next;
  logic signed [SUM_W-1:0]  fb, dither;
  logic                     pdm_clk_reg, pdm_data_reg, underrun_reg;
  logic                     tick, boundary;

  assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_reg == '0);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign tick     = enable && (div_cnt_reg == DIV_W'(HALF));
  assign boundary = tick && (bit_cnt_reg == '0);
  assign pop      = boundary && !empty;
  assign div_next = (div_cnt_reg == DIV_W'(CLK_DIV-1)) ? '0 : div_cnt_reg + 1'b1;

  assign pdmClk   = pdm_clk_reg;
  assign pdmData  = pdm_data_reg;
  assign underrun = underrun_reg;

`ifdef PDM_TX_DITHER_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign dither  = $signed({{(SUM_W-2){lfsr_reg[1]}}, lfsr_reg[1:0]});

  always_ff @(posedge clk) begin
    if (reset)
      lfsr_reg <= 16'hACE1;
    else if (tick)
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
  end
`else
  assign dither = '0;
`endif

  // The boundary tick already modulates the freshly popped sample.
  always_comb begin
    x_eff     = pop ? $signed(mem[rd_ptr_reg]) : x_reg;
    fb        = pdm_data_reg ? FB_POS : FB_NEG;
    acc1_next = sat(sx_acc(acc1_reg) + sx_dat(x_eff) - fb);
    acc2_next = sat(sx_acc(acc2_reg) + sx_acc(acc1_next) - fb + dither);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      x_reg        <= '0;
      acc1_reg     <= '0;
      acc2_reg     <= '0;
      pdm_clk_reg  <= 1'b0;
      pdm_data_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      underrun_reg <= boundary && empty;

      if (!enable) begin
        div_cnt_reg  <= '0;
        bit_cnt_reg  <= '0;
        x_reg        <= '0;
        acc1_reg     <= '0;
        acc2_reg     <= '0;
        pdm_clk_reg  <= 1'b0;
        pdm_data_reg <= 1'b0;
      end else begin
        div_cnt_reg <= div_next;
        pdm_clk_reg <= (div_next < DIV_W'(HALF));
        if (tick) begin
          bit_cnt_reg  <= (bit_cnt_reg == BIT_W'(OSR-1)) ? '0 : bit_cnt_reg + 1'b1;
          x_reg        <= x_eff;
          acc1_reg     <= acc1_next;
          acc2_reg     <= acc2_next;
          pdm_data_reg <= !acc2_next[ACC_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: queue/arithmetic reference model plus directed timing sequences.
module tb_pdm_tx;
  localparam int OSR     = 64;
  localparam int ACC_LIM = 524288;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, pdmClk, pdmData, underrun;

  int total = 0;
  int bad   = 0;

  pdm_tx dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pdmClk   (pdmClk),
    .pdmData  (pdmData),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > ACC_LIM - 1) return ACC_LIM - 1;
    if (v < -ACC_LIM)    return -ACC_LIM;
    return v;
  endfunction

  // Reference model: sample queue, per-bit sigma-delta arithmetic, OSR bits per sample.
  shortint     q[$];
  longint      m_acc1 = 0, m_acc2 = 0;
  int          m_x = 0, m_idx = 0, rec_cnt = 0, fbv;
  bit          m_prev = 0, exp_bit, exp_uf, exp_ready, rec;
  bit          pend_valid = 0;
  logic [15:0] pend_data = '0;
  bit          en_last = 0, rst_last = 1, ok_last, ok_h1 = 0, ok_h2 = 0;
  logic        pc_h1 = 1'b0, pc_h2 = 1'b0;

  always @(negedge clk) begin
    ok_last = en_last && !rst_last;
    if (rst_last) begin
      q.delete();
      pend_valid = 0;
    end
    if (!ok_last) begin
      m_acc1 = 0; m_acc2 = 0; m_x = 0; m_prev = 0; m_idx = 0;
    end
    // A fresh PDM bit is visible two cycles after pdmClk falls.
    rec = ok_last && ok_h1 && ok_h2 && (pdmClk == 1'b0) && (pc_h1 == 1'b0) && (pc_h2 == 1'b1);
    if (rec) begin
      exp_uf = 0;
      if (m_idx % OSR == 0) begin
        if (q.size() > 0) m_x = q.pop_front();
        else              exp_uf = 1;
      end
      fbv     = m_prev ? 32767 : -32768;
      m_acc1  = sat(m_acc1 + m_x - fbv);
      m_acc2  = sat(m_acc2 + m_acc1 - fbv);
      exp_bit = (m_acc2 >= 0);
      m_prev  = exp_bit;
      m_idx++;
      rec_cnt++;
      chk("pdm_bit", pdmData, exp_bit);
      chk("underrun_at_tick", underrun, exp_uf);
    end else begin
      chk("underrun_quiet", underrun, 0);
      if (ok_last) begin
        chk("data_hold", pdmData, m_prev);
      end else begin
        chk("idle_data", pdmData, 0);
        chk("idle_clk", pdmClk, 0);
      end
    end
    if (pend_valid) q.push_back(shortint'(pend_data));
    exp_ready = !reset && (q.size() < 4);
    chk("in_ready", in_ready, exp_ready);
    pend_valid = in_valid && exp_ready;
    pend_data  = in_data;
    ok_h2    = ok_h1;
    ok_h1    = ok_last;
    en_last  = enable;
    rst_last = reset;
    pc_h2    = pc_h1;
    pc_h1    = pdmClk;
  end

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int ucyc[$];
    int rises[$];
    int ucount, highs;
    logic prevc;

    tbl[0] = '{1'b1, 16'h0123, 1'b1};
    tbl[1] = '{1'b1, 16'hF000, 1'b1};
    tbl[2] = '{1'b1, 16'h7FFF, 1'b1};
    tbl[3] = '{1'b1, 16'h8001, 1'b1};
    tbl[4] = '{1'b1, 16'h5555, 1'b0};
    tbl[5] = '{1'b1, 16'hAAAA, 1'b0};

    // Reset state
    cyc(3);
    chk("rst_pdmClk", pdmClk, 0);
    chk("rst_pdmData", pdmData, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1);

    // Single zero sample, then periodic underrun
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    for (int i = 0; i < 2900; i++) begin
      cyc(1);
      in_valid = 1'b0;
      if (underrun) ucyc.push_back(i);
    end
    chk("underrun_count", ucyc.size(), 4);
    for (int i = 1; i < ucyc.size(); i++)
      chk("underrun_spacing", ucyc[i] - ucyc[i-1], 640);

    // Half-scale positive, FIFO kept non-empty
    in_valid = 1'b1;
    in_data  = 16'h4000;
    ucount   = 0;
    for (int i = 0; i < 3200; i++) begin
      cyc(1);
      if (underrun) ucount++;
    end
    chk("underrun_busy_4000", ucount, 0);

    // Full-scale negative exercises accumulator saturation
    in_data = 16'h8000;
    ucount  = 0;
    for (int i = 0; i < 2560; i++) begin
      cyc(1);
      if (underrun) ucount++;
    end
    chk("underrun_busy_8000", ucount, 0);

    // FIFO fill while idle, table driven
    in_valid = 1'b0;
    enable   = 1'b0;
    reset    = 1'b1;
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      #1;
      chk("fill_ready", in_ready, tbl[i].exp_ready);
      cyc(1);
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (i == 1) chk("pdmClk_first_high", pdmClk, 1);
      if (i == 5) chk("ready_before_pop", in_ready, 0);
      if (i == 6) chk("ready_after_pop", in_ready, 1);
    end

    // pdmClk shape: 10-cycle period, 5 high
    cyc(20);
    highs = 0;
    prevc = pdmClk;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (pdmClk) highs++;
      if (pdmClk && !prevc) rises.push_back(i);
      prevc = pdmClk;
    end
    chk("pdmClk_high_cycles", highs, 15);
    chk("pdmClk_rises", rises.size(), 3);
    for (int i = 1; i < rises.size(); i++)
      chk("pdmClk_period", rises[i] - rises[i-1], 10);

    // Random samples, sparse pushes, one enable drop mid-sample
    for (int i = 0; i < 12 * 640; i++) begin
      in_valid = ($urandom_range(0, 299) == 0);
      in_data  = 16'($urandom);
      if (i == 3000) enable = 1'b0;
      if (i == 3037) enable = 1'b1;
      cyc(1);
    end
    in_valid = 1'b0;

    // Reset mid-sample with three samples queued
    enable = 1'b0;
    reset  = 1'b1;
    cyc(1);
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1234 + 16'(i * 4096);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(300);
    reset = 1'b1;
    cyc(1);
    chk("midrst_pdmClk", pdmClk, 0);
    chk("midrst_pdmData", pdmData, 0);
    chk("midrst_in_ready", in_ready, 0);
    cyc(1);
    reset = 1'b0;
    #1;
    chk("midrst_ready_release", in_ready, 1);
    cyc(2000);

    chk("bits_observed", (rec_cnt >= 1500) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
